// File: rtl/sha512core_output_collector.sv
// sha512core_output_collector: pulls one 16x32-bit digest from the core output buffer
// and re-emits it as a 33-halfword packet (header + 32 data halfwords) over valid/ready.
`default_nettype none

module sha512core_output_collector #(
  parameter logic [3:0] CORE_ID       = 4'd0,
  parameter int         START_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        core_out_ready,
  input  logic        core_out_start,
  input  logic        core_out_ctx_num,
  input  logic        core_out_seq_num,
  input  logic [31:0] core_dout,
  output logic        rd_en,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        err_timeout
);

  localparam int CNT_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CAPTURE    = 3'd2,
    SEND_HDR   = 3'd3,
    SEND_DATA  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [4:0]       h_q, h_d;
  logic             rd_en_q, rd_en_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [15:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             ctx_q, ctx_d;
  logic             seq_q, seq_d;

  logic [31:0] mem [16];
  logic [4:0]  hsel;
  logic [31:0] hword;
  logic [15:0] half;
  logic [15:0] header;

  // The stream cannot be stalled, so every CAPTURE cycle writes unconditionally.
  always_ff @(posedge CLK) begin
    if (state_q == CAPTURE) begin
      mem[idx_q] <= core_dout;
    end
  end

  // Halfword to load into the output register on the next transfer.
  always_comb begin
    hsel  = (state_q == SEND_HDR) ? 5'd0 : (h_q + 5'd1);
    hword = mem[hsel[4:1]];
    half  = hsel[0] ? hword[31:16] : hword[15:0];
  end

  assign header = {8'hC5, CORE_ID, 2'b00, ctx_q, seq_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    h_d     = h_q;
    rd_en_d = 1'b0;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    err_d   = err_q;
    ctx_d   = ctx_q;
    seq_d   = seq_q;

    case (state_q)
      IDLE: begin
        if (core_out_ready) begin
          ctx_d   = core_out_ctx_num;
          seq_d   = core_out_seq_num;
          rd_en_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_START;
        end
      end

      WAIT_START: begin
        if (core_out_start) begin
          idx_d   = 4'd0;
          state_d = CAPTURE;
        end else if (cnt_q == CNT_LIMIT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CAPTURE: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          valid_d = 1'b1;
          last_d  = 1'b0;
          data_d  = header;
          state_d = SEND_HDR;
        end
      end

      SEND_HDR: begin
        if (out_ready) begin
          h_d     = 5'd0;
          data_d  = half;
          last_d  = 1'b0;
          state_d = SEND_DATA;
        end
      end

      SEND_DATA: begin
        if (out_ready) begin
          if (h_q == 5'd31) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = 16'h0000;
            state_d = IDLE;
          end else begin
            h_d    = h_q + 5'd1;
            data_d = half;
            last_d = (h_q == 5'd30);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      h_q     <= 5'd0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
      ctx_q   <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      h_q     <= h_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ctx_q   <= ctx_d;
      seq_q   <= seq_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign out_data    = data_q;
  assign err_timeout = err_q;

endmodule

`default_nettype wire

// File: doc/sha512core_output_collector.md
Name: sha512core_output_collector

Overview:
- Sits directly downstream of the sha512 core's output buffer, one collector per core.
- Pulls one finished 16 x 32-bit result (512-bit digest) from the buffer using the buffer's ready / rd_en / start protocol.
- Stores the result locally and re-emits it to the unit output path as a 33-halfword packet: 1 header halfword, then 32 data halfwords.
- Uses a valid/ready handshake toward the unit, so the unit may stall without ever stalling the core buffer.

Parameters:
- CORE_ID, 0: 4-bit core index placed in the packet header.
- START_TIMEOUT, 15: maximum cycles from the rd_en pulse to core_out_start before the error flag is raised.

Ports:
- CLK, in, 1: single clock.
- rst_n, in, 1: synchronous reset, active-low.
- core_out_ready, in, 1: the buffer holds a result.
- core_out_start, in, 1: one-cycle marker; result data follows.
- core_out_ctx_num, in, 1: context of the result; valid while core_out_ready=1.
- core_out_seq_num, in, 1: sequence bit of the result; valid while core_out_ready=1.
- core_dout, in, 32: result word stream from the buffer.
- rd_en, out, 1: one-cycle pulse that requests the result.
- out_data, out, 16: packet halfword.
- out_valid, out, 1: out_data is valid.
- out_last, out, 1: final halfword of the packet.
- out_ready, in, 1: unit accepts the halfword; a transfer occurs when out_valid & out_ready.
- err_timeout, out, 1: sticky error flag.

Behaviour:
- Reset, applied on any cycle with rst_n=0:
  - rd_en=0, out_valid=0, out_last=0, out_data=0, err_timeout=0.
  - State returns to IDLE; counters are cleared.
  - A transfer in flight is abandoned; core_dout words arriving after reset are ignored.
- Storage: 16 x 32-bit array (distributed RAM), plus registered ctx and seq bits. There is a single packet buffer; capture and send never overlap.
- Buffer timing contract:
  - rd_en is sampled by the buffer only while core_out_ready=1.
  - core_out_ready stays high for up to 2 cycles after rd_en.
  - core_out_start rises 2-3 cycles after rd_en.
  - If core_out_start is high in cycle t, word k (k=0..15) is on core_dout in cycle t+1+k.
  - The stream cannot be stalled.
- States:
  - IDLE: when core_out_ready=1, latch core_out_ctx_num and core_out_seq_num, drive rd_en=1 for exactly one cycle, go to WAIT_START.
  - WAIT_START: rd_en=0 and core_out_ready is ignored. Count cycles. On core_out_start go to CAPTURE with word index=0. If START_TIMEOUT cycles elapse without core_out_start, set err_timeout=1 and go to IDLE.
  - CAPTURE: the cycle after start, and every following cycle, write core_dout to mem[index], index+1. After index 15 is written, go to SEND_HDR. Duration is exactly 16 cycles.
  - SEND_HDR: out_valid=1, out_data = {8'hC5, CORE_ID[3:0], 2'b00, ctx, seq}. Hold until out_ready=1, then go to SEND_DATA with halfword index h=0.
  - SEND_DATA: out_data = h[0] ? mem[h>>1][31:16] : mem[h>>1][15:0]. Low half goes first.
    - out_last=1 when h=31.
    - On each transfer, h+1.
    - On the transfer with h=31: out_valid=0 and out_last=0 next cycle, go to IDLE.
- Output registers are stable while out_valid=1 and out_ready=0. out_valid never drops without a transfer, except on reset.
- Throughput:
  - Minimum 2 cycles from core_out_ready to rd_en re-arm; IDLE re-checks core_out_ready the cycle after returning.
  - A packet with out_ready held at 1 takes 33 consecutive cycles.
  - The next rd_en comes no earlier than the cycle after the last halfword transfers.
- A new core_out_start while in CAPTURE or SEND is impossible by protocol and is ignored.
- err_timeout clears only on reset.

Test Plan:
- Basic transfer: buffer model raises ready with ctx=1, seq=0 and words 32'h0000_0000+k*32'h0101_0101; out_ready=1; CORE_ID=3 → single rd_en pulse; header 16'hC532; halfwords 16'h0000, 16'h0000, 16'h0101, 16'h0101, ... in that order; out_last only on the 33rd beat.
- Back-pressure: out_ready toggling 1,0,0,1 throughout → out_data held steady during stalls; identical halfword sequence; exactly 33 transfers.
- Back-to-back: ready re-asserted immediately after the first packet, ctx toggled → second rd_en only after first packet's out_last transfer; second header bit1 matches new ctx.
- Timeout: rd_en issued, no core_out_start for 15 cycles → err_timeout=1, state IDLE, no out_valid; next good result still delivered correctly.
- Reset mid-capture: rst_n=0 for 1 cycle at capture word 7 → out_valid=0 after reset; remaining stream words produce no packet; next ready → fresh rd_en and full packet.
- Ready glitch: core_out_ready held high 2 cycles after rd_en → exactly one rd_en pulse per result.
